// File: rtl/multdiv_stall_ctrl.sv
// Execute-stage sequencer for the iterative mult/div unit: issues the start pulse, stalls the
// pipeline until the unit reports completion (or the watchdog expires), then retires one writeback.
module multdiv_stall_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5,
    parameter int TIMEOUT    = 40
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  start_mult,
    input  logic                  start_div,
    input  logic [DATA_WIDTH-1:0] operand_A,
    input  logic [DATA_WIDTH-1:0] operand_B,
    input  logic [REG_BITS-1:0]   rd_in,
    output logic [DATA_WIDTH-1:0] md_operandA,
    output logic [DATA_WIDTH-1:0] md_operandB,
    output logic                  md_ctrl_MULT,
    output logic                  md_ctrl_DIV,
    output logic                  cnt_clr,
    output logic                  cnt_en,
    input  logic [DATA_WIDTH-1:0] md_result,
    input  logic                  md_exception,
    input  logic                  md_resultRDY,
    output logic                  stall,
    output logic                  wb_valid,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic [REG_BITS-1:0]   wb_rd,
    output logic                  wb_exception
);

    localparam int WD_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_op_div;
    logic [DATA_WIDTH-1:0] r_opa;
    logic [DATA_WIDTH-1:0] r_opb;
    logic [REG_BITS-1:0]   r_rd;
    logic [WD_W-1:0]       r_wd;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_wb_exc;
    logic                  w_start;
    logic                  w_timeout;

    assign w_start   = start_mult | start_div;
    assign w_timeout = (r_wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_START;
            S_START: w_next = S_BUSY;
            S_BUSY:  if (md_resultRDY || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Reset gates stall too, so an abort releases the pipeline in the same cycle.
    always_comb begin
        md_ctrl_MULT = 1'b0;
        md_ctrl_DIV  = 1'b0;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        case (r_state)
            S_IDLE:  stall = w_start & ~ctrl_reset;
            S_START: begin
                md_ctrl_MULT = ~r_op_div;
                md_ctrl_DIV  = r_op_div;
                cnt_clr      = 1'b1;
                stall        = 1'b1;
            end
            S_BUSY: begin
                cnt_en = 1'b1;
                stall  = 1'b1;
            end
            S_DONE:  wb_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            r_op_div  <= 1'b0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_rd      <= '0;
            r_wd      <= '0;
            r_wb_data <= '0;
            r_wb_exc  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_opa    <= operand_A;
                    r_opb    <= operand_B;
                    r_rd     <= rd_in;
                    r_op_div <= ~start_mult;
                end
                S_START: r_wd <= '0;
                S_BUSY: begin
                    r_wd <= r_wd + WD_W'(1);
                    if (md_resultRDY) begin
                        r_wb_data <= md_result;
                        r_wb_exc  <= md_exception;
                    end else if (w_timeout) begin
                        r_wb_data <= '0;
                        r_wb_exc  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign md_operandA  = r_opa;
    assign md_operandB  = r_opb;
    assign wb_data      = r_wb_data;
    assign wb_rd        = r_rd;
    assign wb_exception = r_wb_exc;

endmodule

// File: tb/tb_multdiv_stall_ctrl.sv
// Directed bench for multdiv_stall_ctrl with a behavioural 32-count counter and mult/div unit model.
module tb_multdiv_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_mult = 1'b0;
    logic        start_div = 1'b0;
    logic [31:0] opA = '0;
    logic [31:0] opB = '0;
    logic [4:0]  rd_in = '0;
    logic [31:0] md_operandA, md_operandB, md_result, wb_data;
    logic        md_ctrl_MULT, md_ctrl_DIV, cnt_clr, cnt_en, md_exception, md_resultRDY;
    logic        stall, wb_valid, wb_exception;
    logic [4:0]  wb_rd;

    logic        rdy_tie0 = 1'b0;
    logic        rdy_force1 = 1'b0;
    logic [5:0]  cnt = '0;
    logic        is_div = 1'b0;

    int checks = 0;
    int errors = 0;

    multdiv_stall_ctrl dut (
        .clock(clk), .ctrl_reset(rst), .start_mult(start_mult), .start_div(start_div),
        .operand_A(opA), .operand_B(opB), .rd_in(rd_in),
        .md_operandA(md_operandA), .md_operandB(md_operandB),
        .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV),
        .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .md_result(md_result), .md_exception(md_exception), .md_resultRDY(md_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_exception(wb_exception)
    );

    always #5 clk = ~clk;

    // Environment: completion counter plus a mult/div unit that remembers the last start pulse.
    always @(posedge clk) begin
        if (cnt_clr)     cnt <= '0;
        else if (cnt_en) cnt <= cnt + 6'd1;
        if (md_ctrl_DIV)  is_div <= 1'b1;
        if (md_ctrl_MULT) is_div <= 1'b0;
    end
    assign md_resultRDY = rdy_force1 | (!rdy_tie0 && cnt_en && cnt == 6'd32);
    assign md_result    = is_div ? ((md_operandB == 0) ? 32'd0 : md_operandA / md_operandB)
                                 : md_operandA * md_operandB;
    assign md_exception = is_div && (md_operandB == 0);

    // Issue one op, drop start after the issue edge, observe n cycles; reports counts.
    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int n,
                          output int n_stall, output int n_mult, output int n_div, output int n_en,
                          output int n_wbv, output int wbv_cyc,
                          output logic [31:0] data, output logic [4:0] wrd, output logic exc);
        n_stall = 0; n_mult = 0; n_div = 0; n_en = 0; n_wbv = 0; wbv_cyc = -1;
        data = 'x; wrd = 'x; exc = 1'bx;
        @(negedge clk);
        start_mult = m; start_div = d; opA = a; opB = b; rd_in = rd;
        #1;
        if (stall) n_stall++;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start_mult = 1'b0; start_div = 1'b0;
            #1;
            if (stall)        n_stall++;
            if (md_ctrl_MULT) n_mult++;
            if (md_ctrl_DIV)  n_div++;
            if (cnt_en)       n_en++;
            if (wb_valid) begin
                n_wbv++; wbv_cyc = i + 2;
                data = wb_data; wrd = wb_rd; exc = wb_exception;
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall); end
        checks++; if ({md_ctrl_MULT, md_ctrl_DIV, cnt_clr, cnt_en, wb_valid, wb_exception} !== 6'b0) begin
            errors++; $display("FAIL reset_ctrl got %b exp 000000",
                               {md_ctrl_MULT, md_ctrl_DIV, cnt_clr, cnt_en, wb_valid, wb_exception}); end
        checks++; if ({md_operandA, md_operandB, wb_data, wb_rd} !== 101'b0) begin
            errors++; $display("FAIL reset_data got %h %h %h %h exp 0", md_operandA, md_operandB, wb_data, wb_rd); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_mult;
        int ns, nm, nd, ne, nw, wc; logic [31:0] dt; logic [4:0] r; logic e;
        run_op(1'b1, 1'b0, 32'd7, 32'd6, 5'd3, 40, ns, nm, nd, ne, nw, wc, dt, r, e);
        checks++; if (ns != 35) begin errors++; $display("FAIL mult_stall_cycles got %0d exp 35", ns); end
        checks++; if (nm != 1 || nd != 0) begin errors++; $display("FAIL mult_pulses got mult=%0d div=%0d exp 1 0", nm, nd); end
        checks++; if (nw != 1) begin errors++; $display("FAIL mult_wb_count got %0d exp 1", nw); end
        checks++; if (wc != 36) begin errors++; $display("FAIL mult_wb_cycle got %0d exp 36", wc); end
        checks++; if (dt !== 32'd42) begin errors++; $display("FAIL mult_wb_data got %0d exp 42", dt); end
        checks++; if (r !== 5'd3) begin errors++; $display("FAIL mult_wb_rd got %0d exp 3", r); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL mult_wb_exc got %0b exp 0", e); end
        checks++; if (md_operandA !== 32'd7 || wb_data !== 32'd42) begin
            errors++; $display("FAIL mult_hold got opA=%0d wb_data=%0d exp 7 42", md_operandA, wb_data); end
    endtask

    task automatic test_div_by_zero;
        int ns, nm, nd, ne, nw, wc; logic [31:0] dt; logic [4:0] r; logic e;
        run_op(1'b0, 1'b1, 32'd100, 32'd0, 5'd9, 40, ns, nm, nd, ne, nw, wc, dt, r, e);
        checks++; if (nd != 1 || nm != 0) begin errors++; $display("FAIL div_pulses got div=%0d mult=%0d exp 1 0", nd, nm); end
        checks++; if (nw != 1) begin errors++; $display("FAIL div_wb_count got %0d exp 1", nw); end
        checks++; if (e !== 1'b1) begin errors++; $display("FAIL div_wb_exc got %0b exp 1", e); end
        checks++; if (r !== 5'd9) begin errors++; $display("FAIL div_wb_rd got %0d exp 9", r); end
    endtask

    task automatic test_both_starts;
        int ns, nm, nd, ne, nw, wc; logic [31:0] dt; logic [4:0] r; logic e;
        run_op(1'b1, 1'b1, 32'd5, 32'd9, 5'd4, 40, ns, nm, nd, ne, nw, wc, dt, r, e);
        checks++; if (nm != 1 || nd != 0) begin errors++; $display("FAIL both_pulses got mult=%0d div=%0d exp 1 0", nm, nd); end
        checks++; if (dt !== 32'd45) begin errors++; $display("FAIL both_wb_data got %0d exp 45", dt); end
    endtask

    task automatic test_timeout;
        int ns, nm, nd, ne, nw, wc; logic [31:0] dt; logic [4:0] r; logic e;
        rdy_tie0 = 1'b1;
        run_op(1'b1, 1'b0, 32'd3, 32'd3, 5'd6, 50, ns, nm, nd, ne, nw, wc, dt, r, e);
        rdy_tie0 = 1'b0;
        checks++; if (ne != 40) begin errors++; $display("FAIL tmo_busy_cycles got %0d exp 40", ne); end
        checks++; if (ns != 42) begin errors++; $display("FAIL tmo_stall_cycles got %0d exp 42", ns); end
        checks++; if (nw != 1) begin errors++; $display("FAIL tmo_wb_count got %0d exp 1", nw); end
        checks++; if (dt !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL tmo_wb got data=%0d exc=%0b exp 0 1", dt, e); end
    endtask

    task automatic test_rdy_idle;
        int nw;
        nw = 0;
        rdy_force1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            if (wb_valid || stall) nw++;
        end
        rdy_force1 = 1'b0;
        checks++; if (nw != 0) begin errors++; $display("FAIL rdy_idle_ignored got %0d active cycles exp 0", nw); end
    endtask

    task automatic test_reset_midop;
        int nw, ns, nm, nd, ne, wc; logic [31:0] dt; logic [4:0] r; logic e;
        @(negedge clk);
        start_mult = 1'b1; opA = 32'd11; opB = 32'd13; rd_in = 5'd8;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            start_mult = 1'b0;
        end
        #1;
        checks++; if (cnt_en !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %0b exp 1", cnt_en); end
        rst = 1'b1;
        #1;
        checks++; if (stall !== 1'b0 || cnt_en !== 1'b0) begin
            errors++; $display("FAIL rst_abort_ctrl got stall=%0b cnt_en=%0b exp 0 0", stall, cnt_en); end
        checks++; if ({md_operandA, md_operandB, wb_data, wb_rd, wb_exception} !== 102'b0) begin
            errors++; $display("FAIL rst_abort_data got %h %h %h %h %b exp 0", md_operandA, md_operandB, wb_data, wb_rd, wb_exception); end
        @(negedge clk); rst = 1'b0;
        nw = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (wb_valid) nw++;
        end
        checks++; if (nw != 0) begin errors++; $display("FAIL rst_no_wb got %0d exp 0", nw); end
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 5'd7, 40, ns, nm, nd, ne, nw, wc, dt, r, e);
        checks++; if (nw != 1 || dt !== 32'd12 || r !== 5'd7) begin
            errors++; $display("FAIL rst_restart got wb=%0d data=%0d rd=%0d exp 1 12 7", nw, dt, r); end
    endtask

    task automatic test_back_to_back;
        int nclr, nwbv, done_idx, clr2_idx;
        logic [31:0] d1, d2; logic [4:0] r1, r2;
        nclr = 0; nwbv = 0; done_idx = -1; clr2_idx = -1;
        d1 = 'x; d2 = 'x; r1 = 'x; r2 = 'x;
        @(negedge clk);
        start_mult = 1'b1; opA = 32'd2; opB = 32'd3; rd_in = 5'd1;
        for (int i = 0; i < 90; i++) begin
            @(negedge clk); #1;
            if (cnt_clr) begin
                nclr++;
                if (nclr == 2) begin clr2_idx = i; start_mult = 1'b0; end
            end
            if (wb_valid) begin
                nwbv++;
                if (nwbv == 1) begin
                    d1 = wb_data; r1 = wb_rd; done_idx = i;
                    opA = 32'd4; opB = 32'd5; rd_in = 5'd2;
                end else begin
                    d2 = wb_data; r2 = wb_rd;
                end
            end
        end
        start_mult = 1'b0;
        checks++; if (nwbv != 2) begin errors++; $display("FAIL b2b_wb_count got %0d exp 2", nwbv); end
        checks++; if (d1 !== 32'd6 || r1 !== 5'd1) begin errors++; $display("FAIL b2b_first got data=%0d rd=%0d exp 6 1", d1, r1); end
        checks++; if (d2 !== 32'd20 || r2 !== 5'd2) begin errors++; $display("FAIL b2b_second got data=%0d rd=%0d exp 20 2", d2, r2); end
        checks++; if (nclr != 2) begin errors++; $display("FAIL b2b_clr_count got %0d exp 2", nclr); end
        checks++; if (clr2_idx != done_idx + 2) begin
            errors++; $display("FAIL b2b_second_start got START at %0d exp %0d", clr2_idx, done_idx + 2); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div_by_zero();
        test_both_starts();
        test_timeout();
        test_rdy_idle();
        test_reset_midop();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
